// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core fetch/data ports and memory command port of the arbiter
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: one-at-a-time fetch/data arbiter for a single-ported memory (MEM_ARB_RR_EN selects round-robin ties)
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic            clk,
  input logic            reset,
  mem_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
  state_t state;
  logic   pick_d;
`ifdef MEM_ARB_RR_EN
  logic rr_d;
  // Tie goes to the requester the pointer names; otherwise whoever is asking.
  always_comb pick_d = bus.d_req & (~bus.if_req | rr_d);
  // Pointer moves away from each grant winner.
  always_ff @(posedge clk or posedge reset)
    if (reset) rr_d <= 1'b1;
    else if (state == IDLE && (bus.if_req | bus.d_req)) rr_d <= ~pick_d;
`else
  // Data always beats fetch.
  always_comb pick_d = bus.d_req;
`endif
  // Grant, drive the memory until ready, then pulse the matching ack for one cycle.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= IDLE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {AW{1'b0}};
      bus.mem_wdata <= {DW{1'b0}};
      bus.if_ack    <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.if_rdata  <= {DW{1'b0}};
      bus.d_rdata   <= {DW{1'b0}};
    end else
      case (state)
        IDLE:
          if (bus.if_req | bus.d_req) begin
            state        <= pick_d ? BUSY_D : BUSY_I;
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= pick_d & bus.d_we;
            bus.mem_addr <= pick_d ? bus.d_addr : bus.if_addr;
            if (pick_d) bus.mem_wdata <= bus.d_wdata;
          end
        BUSY_I, BUSY_D:
          if (bus.mem_ready) begin
            state       <= RESP;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            if (state == BUSY_I) begin
              bus.if_ack   <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end else begin
              bus.d_ack <= 1'b1;
              if (!bus.mem_we) bus.d_rdata <= bus.mem_rdata;
            end
          end
        default: begin
          state      <= IDLE;
          bus.if_ack <= 1'b0;
          bus.d_ack  <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic checked against a transaction-level model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0, n_err = 0;
  int grants = 0, n_ack = 0, g0 = 0;
  mem_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_arbiter #(.AW(32), .DW(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: who owns the memory, whether an ack is showing, who won last.
  int owner = -1;
  bit acking = 1'b0, last_d = 1'b0, win_d;
  logic e_req, e_we, e_iack, e_dack;
  logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;

  task automatic model_reset();
    owner = -1; acking = 0; last_d = 0;
    e_req = 0; e_we = 0; e_iack = 0; e_dack = 0;
    e_addr = 0; e_wdata = 0; e_irdata = 0; e_drdata = 0;
  endtask

  task automatic model_step();
    e_iack = 0;
    e_dack = 0;
    if (acking) acking = 0;
    else if (owner < 0) begin
      if (bus.if_req || bus.d_req) begin
`ifdef MEM_ARB_RR_EN
        win_d = bus.d_req && (!bus.if_req || !last_d);
`else
        win_d = bus.d_req;
`endif
        last_d = win_d;
        owner = win_d ? 1 : 0;
        e_req = 1;
        e_we = win_d && bus.d_we;
        e_addr = win_d ? bus.d_addr : bus.if_addr;
        if (win_d) e_wdata = bus.d_wdata;
        grants++;
      end
    end else if (bus.mem_ready) begin
      if (owner == 1) begin
        e_dack = 1;
        if (!e_we) e_drdata = bus.mem_rdata;
      end else begin
        e_iack = 1;
        e_irdata = bus.mem_rdata;
      end
      e_req = 0;
      e_we = 0;
      owner = -1;
      acking = 1;
    end
  endtask

  // Single compare process: advance the model at each edge, check all outputs just after.
  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
    #1;
    chk("mem_req", bus.mem_req, e_req);
    chk("mem_we", bus.mem_we, e_we);
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wdata);
    chk("if_ack", bus.if_ack, e_iack);
    chk("d_ack", bus.d_ack, e_dack);
    chk("if_rdata", bus.if_rdata, e_irdata);
    chk("d_rdata", bus.d_rdata, e_drdata);
    chk("ack_excl", bus.if_ack && bus.d_ack, 1'b0);
    if (bus.if_ack || bus.d_ack) chk("req_in_resp", bus.mem_req, 1'b0);
  end

  task automatic wait_ack(output bit is_d, output bit ok);
    ok = 0;
    is_d = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.if_ack || bus.d_ack) begin
        ok = 1;
        is_d = bus.d_ack;
        return;
      end
    end
  endtask

  bit is_d, ok;

  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_ready = 1; bus.mem_rdata = 0;
    reset = 1;
    tick();
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_if_ack", bus.if_ack, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    tick();
    reset = 0;
    // Fetch with ready tied high.
    bus.mem_rdata = 32'h00500113;
    bus.if_req = 1; bus.if_addr = 32'h0;
    tick();
    chk("s1_mem_req", bus.mem_req, 1'b1);
    chk("s1_mem_we", bus.mem_we, 1'b0);
    tick();
    chk("s1_if_ack", bus.if_ack, 1'b1);
    chk("s1_if_rdata", bus.if_rdata, 32'h00500113);
    chk("s1_req_low", bus.mem_req, 1'b0);
    bus.if_req = 0;
    tick();
    chk("s1_ack_pulse", bus.if_ack, 1'b0);
    // Store.
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 132; bus.d_wdata = 32'hABCDE02E;
    tick();
    chk("s2_mem_we", bus.mem_we, 1'b1);
    chk("s2_mem_addr", bus.mem_addr, 32'd132);
    chk("s2_mem_wdata", bus.mem_wdata, 32'hABCDE02E);
    tick();
    chk("s2_d_ack", bus.d_ack, 1'b1);
    chk("s2_d_rdata", bus.d_rdata, 32'h0);
    bus.d_req = 0;
    tick();
    // Load with four wait states.
    bus.mem_ready = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("s3_hold_req", bus.mem_req, 1'b1);
      chk("s3_hold_addr", bus.mem_addr, 32'h40);
      chk("s3_no_ack", bus.d_ack, 1'b0);
      if (i < 4) tick();
    end
    bus.mem_ready = 1; bus.mem_rdata = 32'h12345678;
    tick();
    chk("s3_d_ack", bus.d_ack, 1'b1);
    chk("s3_d_rdata", bus.d_rdata, 32'h12345678);
    chk("s3_no_if_ack", bus.if_ack, 1'b0);
    bus.d_req = 0;
    tick();
    chk("s3_ack_pulse", bus.d_ack, 1'b0);
    // Fresh reset so the tie pointer starts at data.
    reset = 1;
    tick();
    reset = 0;
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
    for (int g = 0; g < 4; g++) begin
      wait_ack(is_d, ok);
      chk("s4_ack_seen", ok, 1'b1);
`ifdef MEM_ARB_RR_EN
      chk("s4_winner", is_d, (g % 2) == 0);
`else
      chk("s4_winner", is_d, 1'b1);
`endif
    end
    bus.if_req = 0; bus.d_req = 0;
    tick();
    // Reset in the middle of a stalled load.
    bus.mem_ready = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
    tick();
    chk("s5_busy", bus.mem_req, 1'b1);
    #3 reset = 1;
    #1;
    chk("s5_async_drop", bus.mem_req, 1'b0);
    chk("s5_no_ack", bus.d_ack, 1'b0);
    tick();
    reset = 0;
    bus.mem_ready = 1;
    tick();
    chk("s5_regrant", bus.mem_req, 1'b1);
    chk("s5_addr", bus.mem_addr, 32'h300);
    tick();
    chk("s5_d_ack", bus.d_ack, 1'b1);
    bus.d_req = 0;
    tick();
    // Random traffic with protocol-abiding requesters.
    g0 = grants;
    for (int c = 0; c < 2000; c++) begin
      if (bus.if_ack) begin
        n_ack++;
        if ($urandom % 2) bus.if_req = 0;
        else bus.if_addr = $urandom;
      end else if (!bus.if_req && $urandom % 3 == 0) begin
        bus.if_req = 1;
        bus.if_addr = $urandom;
      end
      if (bus.d_ack) begin
        n_ack++;
        if ($urandom % 2) bus.d_req = 0;
        else begin
          bus.d_we = $urandom % 2; bus.d_addr = $urandom; bus.d_wdata = $urandom;
        end
      end else if (!bus.d_req && $urandom % 3 == 0) begin
        bus.d_req = 1; bus.d_we = $urandom % 2; bus.d_addr = $urandom; bus.d_wdata = $urandom;
      end
      bus.mem_ready = $urandom % 2;
      bus.mem_rdata = $urandom;
      tick();
    end
    bus.mem_ready = 1;
    for (int c = 0; c < 100 && (bus.if_req || bus.d_req); c++) begin
      if (bus.if_ack) begin n_ack++; bus.if_req = 0; end
      if (bus.d_ack) begin n_ack++; bus.d_req = 0; end
      if (bus.if_req || bus.d_req) tick();
    end
    chk("drain_done", bus.if_req || bus.d_req, 1'b0);
    tick();
    tick();
    chk("acks_eq_grants", n_ack, grants - g0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
